// File: rtl/pf_lanectrl_pause_ctrl_if.sv
// ---------------------------------------------------------------------------
// pf_lanectrl_pause_ctrl_if
//
// Purpose : Groups the per-lane pause request and the conditioned pause
//           outputs exchanged between the lane-control/training logic and
//           the pause controller that feeds the IOD lanes.
//
// Signals (NUM_LANES lanes):
//   HS_IO_CLK_PAUSE       [NUM_LANES]  asynchronous level pause request
//   HS_IO_CLK_PAUSE_SYNC  [NUM_LANES]  conditioned pause to the IOD lanes
//   PAUSE_DONE            [NUM_LANES]  one-cycle pulse when a lane returns to IDLE
//   PAUSE_ANY             [1]          OR of HS_IO_CLK_PAUSE_SYNC
//
// Modports:
//   master : lane-control side (drives requests, observes results)
//   slave  : pause controller (samples requests, drives results)
// ---------------------------------------------------------------------------
interface pf_lanectrl_pause_ctrl_if #(
  parameter int NUM_LANES = 4
);

  logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE;
  logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE_SYNC;
  logic [NUM_LANES-1:0] PAUSE_DONE;
  logic                 PAUSE_ANY;

  modport master (
    output HS_IO_CLK_PAUSE,
    input  HS_IO_CLK_PAUSE_SYNC,
    input  PAUSE_DONE,
    input  PAUSE_ANY
  );

  modport slave (
    input  HS_IO_CLK_PAUSE,
    output HS_IO_CLK_PAUSE_SYNC,
    output PAUSE_DONE,
    output PAUSE_ANY
  );

endinterface : pf_lanectrl_pause_ctrl_if

// File: rtl/pf_lanectrl_pause_ctrl.sv
// ---------------------------------------------------------------------------
// pf_lanectrl_pause_ctrl
//
// Purpose : Multi-lane HS_IO_CLK pause controller. Each lane synchronises its
//           asynchronous pause request, then a small FSM guarantees a minimum
//           pause width and a minimum low gap between pauses. A request that
//           arrives during the gap is remembered and serviced right after it.
//
// Parameters:
//   NUM_LANES         independent pause lanes                 (1..8)
//   SYNC_STAGES       synchroniser flops per lane             (2..4)
//   MIN_PAUSE_CYCLES  minimum output pause width, CLK cycles  (1..16)
//   GAP_CYCLES        minimum low time after a pause          (0..16)
//
// Ports:
//   CLK     lane-control clock (rising edge, plus optional falling-edge retime)
//   RESETN  asynchronous active-low reset
//   bus     pf_lanectrl_pause_ctrl_if.slave
//             HS_IO_CLK_PAUSE       in   per-lane async request (level)
//             HS_IO_CLK_PAUSE_SYNC  out  conditioned pause per lane
//             PAUSE_DONE            out  one-cycle pulse on return to IDLE
//             PAUSE_ANY             out  OR of HS_IO_CLK_PAUSE_SYNC
//
// Build option:
//   PF_LANECTRL_PAUSE_FALL_EDGE_EN  when defined, every HS_IO_CLK_PAUSE_SYNC
//   bit is retimed through a falling-edge flop (half-cycle later) and
//   PAUSE_ANY is formed after that retime. PAUSE_DONE is never retimed.
// ---------------------------------------------------------------------------
module pf_lanectrl_pause_ctrl #(
  parameter int NUM_LANES        = 4,
  parameter int SYNC_STAGES      = 2,
  parameter int MIN_PAUSE_CYCLES = 4,
  parameter int GAP_CYCLES       = 2
) (
  input  logic                            CLK,
  input  logic                            RESETN,
  pf_lanectrl_pause_ctrl_if.slave         bus
);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter guards
  // -------------------------------------------------------------------------
  if (NUM_LANES < 1 || NUM_LANES > 8) begin : g_bad_lanes
    $error("pf_lanectrl_pause_ctrl: NUM_LANES must be 1..8");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("pf_lanectrl_pause_ctrl: SYNC_STAGES must be 2..4");
  end
  if (MIN_PAUSE_CYCLES < 1 || MIN_PAUSE_CYCLES > 16) begin : g_bad_min
    $error("pf_lanectrl_pause_ctrl: MIN_PAUSE_CYCLES must be 1..16");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 16) begin : g_bad_gap
    $error("pf_lanectrl_pause_ctrl: GAP_CYCLES must be 0..16");
  end

  // -------------------------------------------------------------------------
  // Per-lane FSM encoding and counter reload values
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  // The counter counts down to zero inclusive, so an N-cycle phase loads N-1.
  localparam logic [3:0] PAUSE_LOAD = 4'(MIN_PAUSE_CYCLES - 1);
  localparam bit         GAP_EN     = (GAP_CYCLES != 0);
  localparam logic [3:0] GAP_LOAD   = GAP_EN ? 4'(GAP_CYCLES - 1) : 4'd0;

  logic [NUM_LANES-1:0] pause_vec;  // rising-edge output register, per lane
  logic [NUM_LANES-1:0] done_vec;   // registered PAUSE_DONE, per lane
  logic [NUM_LANES-1:0] sync_out;   // value presented on HS_IO_CLK_PAUSE_SYNC

  // -------------------------------------------------------------------------
  // Lanes: synchroniser + FSM, fully independent of each other
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q;
    logic [3:0]             cnt_q;
    logic                   pending_q;
    logic                   pause_q;
    logic                   done_q;

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: every register here is assigned with <= so all lanes and the
    // synchroniser chain see the values from before the edge; blocking '='
    // would let the chain collapse into a single stage in simulation.
    always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
        sync_q    <= '0;
        state_q   <= ST_IDLE;
        cnt_q     <= 4'd0;
        pending_q <= 1'b0;
        pause_q   <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.HS_IO_CLK_PAUSE[i]};
        done_q <= 1'b0;

        unique case (state_q)
          ST_IDLE: begin
            if (s || pending_q) begin
              state_q   <= ST_ASSERT;
              cnt_q     <= PAUSE_LOAD;
              pending_q <= 1'b0;
              pause_q   <= 1'b1;
            end
          end

          ST_ASSERT: begin
            // Requests arriving here are absorbed by the pause in progress.
            if (cnt_q != 4'd0) begin
              cnt_q <= cnt_q - 4'd1;
            end else if (s) begin
              state_q <= ST_HOLD;
            end else if (GAP_EN) begin
              state_q <= ST_GAP;
              cnt_q   <= GAP_LOAD;
              pause_q <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              pause_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end

          ST_HOLD: begin
            if (!s) begin
              pause_q <= 1'b0;
              if (GAP_EN) begin
                state_q <= ST_GAP;
                cnt_q   <= GAP_LOAD;
              end else begin
                state_q <= ST_IDLE;
                done_q  <= 1'b1;
              end
            end
          end

          ST_GAP: begin
            // Output stays low; a request seen now is replayed from IDLE.
            if (s) begin
              pending_q <= 1'b1;
            end
            if (cnt_q == 4'd0) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end

          default: begin
            state_q <= ST_IDLE;
            pause_q <= 1'b0;
          end
        endcase
      end
    end

    assign pause_vec[i] = pause_q;
    assign done_vec[i]  = done_q;

  end : g_lane

  // -------------------------------------------------------------------------
  // Output stage
  // -------------------------------------------------------------------------
`ifdef PF_LANECTRL_PAUSE_FALL_EDGE_EN
  logic [NUM_LANES-1:0] pause_fe_q;

  // Half-cycle retime so the IOD lanes see the pause change away from the
  // rising edge that clocks the lane-control logic.
  always_ff @(negedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pause_fe_q <= '0;
    end else begin
      pause_fe_q <= pause_vec;
    end
  end

  assign sync_out = pause_fe_q;
`else
  assign sync_out = pause_vec;
`endif

  assign bus.HS_IO_CLK_PAUSE_SYNC = sync_out;
  assign bus.PAUSE_DONE           = done_vec;
  assign bus.PAUSE_ANY            = |sync_out;

endmodule : pf_lanectrl_pause_ctrl

// File: doc/pf_lanectrl_pause_ctrl.md
# pf_lanectrl_pause_ctrl

Multi-lane pause controller for the PF_LANECTRL high-speed I/O clock-pause path. It generalises the single-bit pause synchroniser in four ways:
- N independent lanes.
- Configurable synchroniser depth.
- A guaranteed minimum pause width, which replaces the fixed one-cycle extension.
- A guaranteed minimum gap between pauses, with short-request capture during that gap.

It sits between the lane-control/training logic and the HS_IO_CLK pause inputs of the IOD lanes.

## Interface
- NUM_LANES, 4, number of independent pause lanes (1..8)
- SYNC_STAGES, 2, synchroniser flops per lane (2..4)
- MIN_PAUSE_CYCLES, 4, minimum output pause width in CLK cycles (1..16)
- GAP_CYCLES, 2, minimum low time after a pause ends (0..16)

Ports (clock and reset first):
- CLK  input  1  lane-control clock; all logic on its rising edge except the optional output stage
- RESETN  input  1  asynchronous, active-low reset
- HS_IO_CLK_PAUSE  input  NUM_LANES  asynchronous per-lane pause request (level)
- HS_IO_CLK_PAUSE_SYNC  output  NUM_LANES  conditioned pause to the IOD lanes
- PAUSE_DONE  output  NUM_LANES  one-cycle pulse when a lane returns to IDLE after a pause
- PAUSE_ANY  output  1  OR of HS_IO_CLK_PAUSE_SYNC

## Operation
- Per lane, HS_IO_CLK_PAUSE passes through a SYNC_STAGES-deep flop chain. Its last stage is called `s`.
- Per-lane FSM (IDLE, ASSERT, HOLD, GAP), 4-bit down-counter `cnt`, 1-bit `pending`.
- IDLE:
  - On `s=1` or `pending=1`: go to ASSERT, load `cnt=MIN_PAUSE_CYCLES-1`, clear `pending`.
- ASSERT:
  - While `cnt!=0`: decrement `cnt`.
  - At `cnt==0` with `s=1`: go to HOLD.
  - At `cnt==0` with `s=0`: go to GAP with `cnt=GAP_CYCLES-1`, or go straight to IDLE if GAP_CYCLES=0.
- HOLD:
  - Stay while `s=1`.
  - On `s=0`: go to GAP, or to IDLE if GAP_CYCLES=0.
- GAP:
  - Output low. Decrement `cnt`.
  - `s=1` sampled in any GAP cycle sets `pending`.
  - At `cnt==0`: go to IDLE.
- Output register is 1 exactly while the state is ASSERT or HOLD. It is set on the edge entering ASSERT and cleared on the edge leaving HOLD or ASSERT.
- PAUSE_DONE[i] is registered. It is high for the one cycle following the edge that enters IDLE from GAP, or from ASSERT/HOLD when GAP_CYCLES=0.
- Requests seen in ASSERT or HOLD are absorbed; they do not set `pending`.
- Lanes are fully independent. Simultaneous requests on any set of lanes are each handled on the same edges.
- Reset (asynchronous assert, synchronous deassert supplied externally):
  - All sync flops, states and counters clear; states go to IDLE and `pending` to 0.
  - HS_IO_CLK_PAUSE_SYNC=0, PAUSE_DONE=0, PAUSE_ANY=0.
  - Reset mid-pause aborts the pause immediately. No pause is replayed after release.

## Timing
- Request-to-output latency is SYNC_STAGES rising edges.
  - An input high at edge 0 raises the output at edge SYNC_STAGES.
- Output width is max(MIN_PAUSE_CYCLES, request width as seen at `s`).
- Low time between consecutive pauses is at least GAP_CYCLES, plus 1 cycle when serviced from `pending`.
- Release-to-output-low latency is SYNC_STAGES+1 edges after the last high sample.
- PAUSE_ANY is combinational from the output flops and carries no extra latency.

## Configuration
- Macro: PF_LANECTRL_PAUSE_FALL_EDGE_EN.
- Defined:
  - Each HS_IO_CLK_PAUSE_SYNC bit is retimed through one falling-edge CLK flop, async-cleared by RESETN, adding half a cycle of latency.
  - PAUSE_ANY is taken after the retime.
  - PAUSE_DONE is not retimed.
- Undefined: outputs come directly from the rising-edge output register.

## Test plan
All scenarios use NUM_LANES=4, SYNC_STAGES=2, MIN_PAUSE_CYCLES=4, GAP_CYCLES=2, macro undefined unless stated.
- Single-cycle pulse on lane 0, sampled at edge 0:
  - SYNC[0] rises at edge 2 and falls at edge 6 (4 cycles).
  - PAUSE_DONE[0] is high for one cycle after edge 8.
  - Other lanes stay 0.
- Lane 1 held high for edges 0..9:
  - SYNC[1] rises at edge 2 and falls at edge 12 (10 cycles, HOLD path).
- Lane 0 pulse at edge 0, second pulse at edge 5 (seen in GAP):
  - `pending` is set.
  - SYNC[0] falls at edge 6, re-rises at edge 9, and stays high 4 cycles.
- All four lanes pulsed at edge 0:
  - All SYNC bits are high at edges 2..5.
  - PAUSE_ANY mirrors them.
  - PAUSE_DONE is 4'b1111 for one cycle after edge 8.
- RESETN low mid-pause at cycle 4:
  - SYNC and PAUSE_ANY drop to 0 asynchronously.
  - After release with no request, outputs stay 0 for 20 cycles.
- Macro defined, SYNC_STAGES=3, single pulse:
  - Output rises at the falling edge after edge 3.
  - Output stays high 4 cycles.
